// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_t       - control FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand/result width in bits
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: single-bit full adder, purely combinational.
//   a, b, cin : input bits
//   s         : sum bit        (a ^ b ^ cin)
//   cout      : carry out bit  (majority of a, b, cin)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor, one bit per clock, LSB first.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request an operation (accepted in IDLE or DONE only)
//   a, b       : operands, sampled on accepted start
//   cin        : carry-in for addition (ignored when sub=1)
//   sub        : 0 = a+b+cin, 1 = a-b
//   busy       : operation in progress
//   done       : one-cycle pulse, result valid
//   sum, cout  : result and carry out of the MSB, held until the next result
//   ovf        : signed overflow, present only with SERIAL_ADDER_OVF_EN defined
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  // Partial result holds the WIDTH-1 bits produced so far; the final bit
  // completes it directly into sum, so partial values never reach the port.
  logic [WIDTH-2:0] acc_q;
  logic [WIDTH-1:0] acc_shift;

  logic             bit_s;
  logic             bit_c;

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign acc_shift = {bit_s, acc_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      cnt_q   <= '0;
    end else if (busy) begin
      // Operands shift right so the active bit is always at index 0.
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= bit_c;
      cnt_q   <= cnt_q + CW'(1);
      acc_q   <= acc_shift[WIDTH-1:1];
      if (last_bit) begin
        sum  <= acc_shift;
        cout <= bit_c;
`ifdef SERIAL_ADDER_OVF_EN
        // carry_q is the carry into the MSB during the last bit.
        ovf  <= carry_q ^ bit_c;
`endif
      end
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port a  input  WIDTH  operand A, sampled only on accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, sampled only on accepted start.
REQ-007 SHALL have port cin  input  1  carry-in, sampled only on accepted start, ignored when sub=1.
REQ-008 SHALL have port sub  input  1  mode: 0 = A+B+cin, 1 = A-B; sampled only on accepted start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking that the result is valid.
REQ-011 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1  carry out of the MSB (for subtraction: 1 = no borrow).

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored with no effect on the operation or the latched operands.
REQ-015 On accept: latch a, latch b (b inverted when sub=1), initialise the carry register to (sub ? 1 : cin), clear the bit counter, go to RUN.
REQ-016 In RUN, each cycle SHALL process one bit, LSB first: s = a_i ^ b'_i ^ c, c_next = a_i&b'_i | c&(a_i^b'_i); s shifts into the sum register from the MSB side.
REQ-017 After WIDTH RUN cycles SHALL go to DONE; done high for exactly that one cycle; DONE then goes to IDLE, or to RUN if start is accepted.
REQ-018 Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH; busy high in the cycles after edges k..k+WIDTH-1.
REQ-019 sum and cout SHALL update only at the RUN->DONE transition and hold until the next operation completes; partial results SHALL NOT be visible on sum.
REQ-020 Back-to-back: start accepted in the DONE cycle SHALL begin a new operation with no idle gap; done still pulses for the completed operation.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE and set busy=0, done=0, sum=0, cout=0 (and ovf=0 when present); the carry, the counter and the operand registers SHALL clear.
REQ-022 rst SHALL take priority over start; reset mid-RUN SHALL abort the operation with no done pulse.

Configuration
REQ-023 With SERIAL_ADDER_OVF_EN defined: output ovf (1 bit) SHALL equal the carry into the MSB XOR the carry out of the MSB, updated and held like cout.
REQ-024 Without SERIAL_ADDER_OVF_EN: the ovf port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-025 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-026 The per-bit sum/carry logic SHALL be a sub-module fa_cell (a, b, cin -> s, cout), purely combinational, instantiated once.
REQ-027 The bit counter width SHALL be $clog2(WIDTH+1).

Verification (WIDTH=8)
REQ-028 fa_cell exhaustive, all 8 input combinations -> s = a^b^cin, cout = majority(a,b,cin).
REQ-029 a=0x5A, b=0x3C, cin=0, sub=0 -> sum=0x96, cout=0, ovf=1, done exactly 8 cycles after start is sampled.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, ovf=1.
REQ-031 sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0; then sub=1, a=0x20, b=0x10 -> sum=0x10, cout=1.
REQ-032 start pulsed again at RUN cycle 3 with different operands -> ignored, original result delivered; start held in the DONE cycle -> second result follows 8 cycles later.
REQ-033 rst asserted at RUN cycle 4 -> next cycle busy=0, sum=0, no done pulse; a fresh start then completes normally.
